ram_sp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `RAM_SP_generic` instance between two requesters. Each requester uses a valid/ready command port and receives read data on a response port. The block drives the RAM's active-low `cen` and `rdwen` controls from registered outputs. It also tracks outstanding reads so that every read returns exactly one `rspN_valid` pulse, aligned to the RAM's configured output latency.

---
 rtl/ram_sp_arbiter.sv | 109 ++++++++++
 tb/tb_ram_sp_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two valid/ready requesters.
// Reads are tracked through a tagged shift pipeline so each returns one rspN_valid pulse.
module ram_sp_arbiter #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 8,
  parameter int Pipelined = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [AddrWidth-1:0] req0_addr,
  input  logic [DataWidth-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [AddrWidth-1:0] req1_addr,
  input  logic [DataWidth-1:0] req1_wdata,
  output logic                 rsp0_valid,
  output logic [DataWidth-1:0] rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [DataWidth-1:0] rsp1_rdata,
  output logic                 ram_cen,
  output logic                 ram_rdwen,
  output logic [AddrWidth-1:0] ram_a,
  output logic [DataWidth-1:0] ram_d,
  input  logic [DataWidth-1:0] ram_q,
  output logic                 busy
);

  localparam int Depth = 2 + Pipelined;

  logic                 gnt0, gnt1, accept;
  logic                 sel_we;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;

  logic                 last_q, last_d;
  logic                 cen_q, cen_d;
  logic                 rdwen_q, rdwen_d;
  logic [AddrWidth-1:0] a_q, a_d;
  logic [DataWidth-1:0] d_q, d_d;
  logic [Depth-1:0]     vld_q, vld_d;
  logic [Depth-1:0]     tag_q, tag_d;

  // last_q=1 means port 1 was granted last, so contention favours port 0
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign sel_we     = gnt1 ? req1_we    : req0_we;
  assign sel_addr   = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata  = gnt1 ? req1_wdata : req0_wdata;

  always_comb begin
    last_d  = accept ? gnt1 : last_q;
    cen_d   = !accept;
    rdwen_d = !(accept && sel_we);
    a_d     = accept ? sel_addr : a_q;
    d_d     = (accept && sel_we) ? sel_wdata : d_q;
    vld_d   = {vld_q[Depth-2:0], accept && !sel_we};
    tag_d   = {tag_q[Depth-2:0], gnt1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 1'b1;
      cen_q   <= 1'b1;
      rdwen_q <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      vld_q   <= '0;
      tag_q   <= '0;
    end else begin
      last_q  <= last_d;
      cen_q   <= cen_d;
      rdwen_q <= rdwen_d;
      a_q     <= a_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
    end
  end

  assign ram_cen    = cen_q;
  assign ram_rdwen  = rdwen_q;
  assign ram_a      = a_q;
  assign ram_d      = d_q;
  assign rsp0_valid = vld_q[Depth-1] && !tag_q[Depth-1];
  assign rsp1_valid = vld_q[Depth-1] &&  tag_q[Depth-1];
  assign rsp0_rdata = ram_q;
  assign rsp1_rdata = ram_q;
  assign busy       = |vld_q;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Drives two arbiters (Pipelined=0 and 1) with shared stimulus; a reference model
// queues expected responses and a monitor checks each returned read.
module tb_ram_sp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
  logic [11:0] a0 = '0, a1 = '0;
  logic [7:0]  d0 = '0, d1 = '0;

  logic        rdy0_w [2];
  logic        rdy1_w [2];
  logic        rv0_w  [2];
  logic        rv1_w  [2];
  logic [7:0]  rd0_w  [2];
  logic [7:0]  rd1_w  [2];
  logic        cen_w  [2];
  logic        rdw_w  [2];
  logic [11:0] ra_w   [2];
  logic [7:0]  rdat_w [2];
  logic        busy_w [2];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int         port;
    int         acc;
    int         due;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, inst, cyc, act, expv);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [4096];
    logic [7:0] q0, q1;
    logic [7:0] ram_q_w;

    initial begin
      for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
      mem[12'hFFF] = 8'h3C;
    end

    always @(posedge clk) begin
      if (cen_w[g] == 1'b0) begin
        if (rdw_w[g] == 1'b0) mem[ra_w[g]] <= rdat_w[g];
        else                  q0 <= mem[ra_w[g]];
      end
      q1 <= q0;
    end
    assign ram_q_w = (g == 1) ? q1 : q0;

    ram_sp_arbiter #(.AddrWidth(12), .DataWidth(8), .Pipelined(g)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(rdy0_w[g]), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
      .req1_valid(v1), .req1_ready(rdy1_w[g]), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
      .rsp0_valid(rv0_w[g]), .rsp0_rdata(rd0_w[g]),
      .rsp1_valid(rv1_w[g]), .rsp1_rdata(rd1_w[g]),
      .ram_cen(cen_w[g]), .ram_rdwen(rdw_w[g]), .ram_a(ra_w[g]), .ram_d(rdat_w[g]),
      .ram_q(ram_q_w), .busy(busy_w[g])
    );
  end

  // Reference model: arbitration, memory contents and expected ram_* registers
  logic [7:0]  mdl_mem [4096];
  logic        mdl_last = 1'b1;
  logic        e_cen = 1'b1, e_rdw = 1'b1;
  logic [11:0] e_a = '0;
  logic [7:0]  e_d = '0;
  logic        m_g0, m_g1, m_we;
  logic [11:0] m_a;
  logic [7:0]  m_d;
  int          grant_log [$];

  initial begin
    for (int i = 0; i < 4096; i++) mdl_mem[i] = init_val(i);
    mdl_mem[12'hFFF] = 8'h3C;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("ram_cen", i, 32'(cen_w[i]), 32'(e_cen));
      chk("ram_rdwen", i, 32'(rdw_w[i]), 32'(e_rdw));
      chk("ram_a", i, 32'(ra_w[i]), 32'(e_a));
      chk("ram_d", i, 32'(rdat_w[i]), 32'(e_d));
    end
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    if (!rst) begin
      if (v0 && v1) begin
        m_g0 = (mdl_last == 1'b1);
        m_g1 = !m_g0;
      end else begin
        m_g0 = v0;
        m_g1 = v1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk("req0_ready", i, 32'(rdy0_w[i]), 32'(m_g0));
      chk("req1_ready", i, 32'(rdy1_w[i]), 32'(m_g1));
    end
    if (rst) begin
      mdl_last = 1'b1;
      e_cen = 1'b1; e_rdw = 1'b1; e_a = '0; e_d = '0;
    end else if (m_g0 || m_g1) begin
      m_we = m_g1 ? we1 : we0;
      m_a  = m_g1 ? a1 : a0;
      m_d  = m_g1 ? d1 : d0;
      grant_log.push_back(m_g1 ? 1 : 0);
      mdl_last = m_g1;
      e_cen = 1'b0;
      e_rdw = !m_we;
      e_a   = m_a;
      if (m_we) begin
        e_d = m_d;
        mdl_mem[m_a] = m_d;
      end else begin
        for (int i = 0; i < 2; i++)
          exp_q[i].push_back('{port: (m_g1 ? 1 : 0), acc: cyc, due: cyc + 2 + i, data: mdl_mem[m_a]});
      end
    end else begin
      e_cen = 1'b1;
      e_rdw = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever a response appears or one is overdue
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic logic bexp = 1'b0;
        automatic exp_t e;
        foreach (exp_q[i][k]) if (exp_q[i][k].acc < cyc) bexp = 1'b1;
        chk("busy", i, 32'(busy_w[i]), 32'(bexp));
        if (rv0_w[i] && rv1_w[i]) chk("both_rsp", i, 32'd1, 32'd0);
        if (rv0_w[i] || rv1_w[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("unexpected_rsp", i, 32'd1, 32'd0);
          end else begin
            e = exp_q[i].pop_front();
            chk("rsp_port", i, rv1_w[i] ? 32'd1 : 32'd0, 32'(e.port));
            chk("rsp_cycle", i, 32'(cyc), 32'(e.due));
            chk("rsp_data", i, 32'(rv1_w[i] ? rd1_w[i] : rd0_w[i]), 32'(e.data));
          end
        end else if (exp_q[i].size() != 0 && exp_q[i][0].due <= cyc) begin
          e = exp_q[i].pop_front();
          chk("missing_rsp", i, 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic drive(logic iv0, logic iwe0, logic [11:0] ia0, logic [7:0] id0,
                       logic iv1, logic iwe1, logic [11:0] ia1, logic [7:0] id1);
    v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
    v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // write then read on port 0
    drive(1, 1, 12'h005, 8'hA5, 0, 0, '0, '0);
    drive(1, 0, 12'h005, 8'h00, 0, 0, '0, '0);
    idle(5);

    // contention fairness straight after reset
    pulse_reset();
    grant_log.delete();
    repeat (6) drive(1, 0, 12'h020, 8'h00, 1, 0, 12'h021, 8'h00);
    for (int k = 0; k < 6; k++) chk("fair_grant", k, 32'(grant_log[k]), 32'(k % 2));
    idle(5);

    // preloaded top address from port 1
    idle(4);
    drive(0, 0, '0, '0, 1, 0, 12'hFFF, 8'h00);
    idle(5);

    // cross-port read-after-write
    drive(0, 0, '0, '0, 1, 1, 12'h010, 8'h77);
    drive(1, 0, 12'h010, 8'h00, 0, 0, '0, '0);
    idle(5);

    // reset with reads in flight
    drive(1, 0, 12'h001, 8'h00, 0, 0, '0, '0);
    drive(0, 0, '0, '0, 1, 0, 12'h002, 8'h00);
    drive(1, 0, 12'h003, 8'h00, 0, 0, '0, '0);
    pulse_reset();
    idle(20);

    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15)), 8'($urandom));
      end
    end
    idle(10);
    for (int i = 0; i < 2; i++) chk("drain", i, 32'(exp_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
